// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and transmit FSM state encodings.
package mmio_uart_tx_pkg;

  // Register select values taken from addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY     = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_CNT_LSB  = 4;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divisor of zero would stall the bit counter, so it is stored as one
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// First-word fall-through synchronous FIFO. A push while full is only
// accepted when a pop happens in the same cycle.
module mmio_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       inclk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // Storage has no reset; validity is tracked by the pointers and count
  always_ff @(posedge inclk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. CPU stores to TXDATA are queued in a
// small FIFO and shifted out LSB first on txd; STATUS and BAUDDIV are
// readable with zero latency.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        inclk,
  input  logic        rstn,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    sel;
  logic          wr_en;
  logic          push_req;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    cnt8;
  logic          overflow;
  logic [15:0]   baud_div;
  logic          busy;
  logic [31:0]   status;
  logic [31:0]   reg_rdata;

  tx_state_e     state;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          txd_q;
  logic          bit_end;

  assign hit      = cs && (addr[31:4] == BASE_ADDR[31:4]);
  assign sel      = addr[3:2];
  assign wr_en    = hit && wr;
  assign push_req = wr_en && (sel == REG_TXDATA);
  assign bit_end  = (bit_cnt == 16'd1);
  assign txd      = txd_q;

  // Pop on leaving IDLE, or at the end of STOP to chain frames with no gap
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || (state == ST_STOP && bit_end));

  mmio_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .inclk (inclk),
    .rstn  (rstn),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy = (state != ST_IDLE) || !fifo_empty;
  assign cnt8 = 8'(fifo_count);

  // STATUS word assembly
  always_comb begin
    status                 = 32'h0;
    status[STAT_BUSY]      = busy;
    status[STAT_FULL]      = fifo_full;
    status[STAT_EMPTY]     = fifo_empty;
    status[STAT_OVERFLOW]  = overflow;
    status[STAT_CNT_LSB+:4] = cnt8[3:0];
  end

  // Register read mux; rdata is zero unless this block is being read
  always_comb begin
    reg_rdata = 32'h0;
    case (sel)
      REG_STATUS:  reg_rdata = status;
      REG_BAUDDIV: reg_rdata = {16'h0, baud_div};
      default:     reg_rdata = 32'h0;
    endcase
    rdata = (hit && rd) ? reg_rdata : 32'h0;
  end

  // Control registers: divisor and sticky overflow (set beats clear)
  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      baud_div <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (wr_en && sel == REG_BAUDDIV) baud_div <= clamp_div(wdata[15:0]);
      if (push_req && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (wr_en && sel == REG_STATUS && wdata[STAT_OVERFLOW]) overflow <= 1'b0;
    end
  end

  // Transmit FSM; the divisor is sampled only at bit-counter reloads
  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      bit_cnt <= 16'd1;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (fifo_pop) begin
            shreg   <= fifo_dout;
            bit_cnt <= baud_div;
            txd_q   <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            bit_cnt <= baud_div;
            bit_idx <= 3'd0;
            txd_q   <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= ST_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= baud_div;
            if (bit_idx == 3'd7) begin
              txd_q <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_q   <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (fifo_pop) begin
              shreg   <= fifo_dout;
              bit_cnt <= baud_div;
              txd_q   <= 1'b0;
              state   <= ST_START;
            end else begin
              txd_q <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          txd_q <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Address byte lanes and upper write data are don't-cares
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16], cnt8[7:4]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: reset state, frame waveforms,
// back-to-back chaining, overflow, address decode and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_BD = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic        inclk = 1'b0;
  logic        rstn  = 1'b0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        hit, txd;

  int n_chk = 0;
  int n_err = 0;

  mmio_uart_tx dut (
    .inclk (inclk),
    .rstn  (rstn),
    .cs    (cs),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .hit   (hit),
    .txd   (txd)
  );

  always #5 inclk = ~inclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle bus write landing on the next rising edge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic c = 1'b1);
    @(negedge inclk);
    cs = c; wr = 1'b1; addr = a; wdata = d;
    @(posedge inclk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  // Combinational read, performed away from clock edges
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1;
    d = rdata; h = hit;
    cs = 1'b0; rd = 1'b0;
  endtask

  // Expected txd level k cycles into a frame of byte b at divisor div
  function automatic logic exp_bit(input logic [7:0] b, input int div, input int k);
    int lvl;
    lvl = k / div;
    if (lvl == 0) return 1'b0;
    if (lvl >= 9) return 1'b1;
    return b[lvl-1];
  endfunction

  // Sample txd and STATUS.busy on n consecutive falling edges
  task automatic capture(input int n, output logic [63:0] w, output logic [63:0] bz);
    logic [31:0] d;
    logic h;
    w = '0; bz = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge inclk);
      w[k] = txd;
      bus_rd(A_ST, d, h);
      bz[k] = d[0];
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    logic [63:0] w, bz, ew;

    // Reset state
    #12;
    chk("rst_txd", 64'(txd), 64'h1);
    bus_rd(A_ST, d, h);
    chk("rst_status", 64'(d), 64'h4);
    chk("rst_hit", 64'(h), 64'h1);
    bus_rd(A_BD, d, h);
    chk("rst_bauddiv", 64'(d), 64'd434);
    @(negedge inclk);
    rstn = 1'b1;

    // Single frame 0x55 at divisor 4
    bus_wr(A_BD, 32'd4);
    bus_wr(A_TX, 32'h55);
    @(negedge inclk);
    chk("tx_before_pop", 64'(txd), 64'h1);
    capture(40, w, bz);
    ew = '0;
    for (int k = 0; k < 40; k++) ew[k] = exp_bit(8'h55, 4, k);
    chk("frame_55", w, ew);
    @(negedge inclk);
    chk("frame_55_idle", 64'(txd), 64'h1);

    // Back-to-back 0xA0, 0x0F at divisor 2
    bus_wr(A_BD, 32'd2);
    bus_wr(A_TX, 32'hA0);
    bus_wr(A_TX, 32'h0F);
    capture(41, w, bz);
    ew = '0;
    for (int k = 0; k < 20; k++) ew[k] = exp_bit(8'hA0, 2, k);
    for (int k = 20; k < 40; k++) ew[k] = exp_bit(8'h0F, 2, k - 20);
    ew[40] = 1'b1;
    chk("b2b_wave", w, ew);
    chk("b2b_busy", bz, {23'h0, 1'b0, 40'hFF_FFFF_FFFF});

    // Overflow at divisor 1000
    bus_wr(A_BD, 32'd1000);
    for (int i = 0; i < 6; i++) bus_wr(A_TX, 32'(8'h10 + i));
    @(negedge inclk);
    bus_rd(A_ST, d, h);
    chk("ovf_status", 64'(d), 64'h4B);
    bus_wr(A_ST, 32'h8);
    @(negedge inclk);
    bus_rd(A_ST, d, h);
    chk("ovf_clear", 64'(d), 64'h43);
    rstn = 1'b0;
    @(negedge inclk);
    rstn = 1'b1;

    // Address decode and register quirks
    @(negedge inclk);
    bus_rd(BASE + 32'h10, d, h);
    chk("oow_hit", 64'(h), 64'h0);
    chk("oow_rdata", 64'(d), 64'h0);
    bus_rd(A_RS, d, h);
    chk("rsvd_rd", 64'(d), 64'h0);
    bus_rd(A_TX, d, h);
    chk("txdata_rd", 64'(d), 64'h0);
    bus_wr(A_BD, 32'h0);
    @(negedge inclk);
    bus_rd(A_BD, d, h);
    chk("div0_as_1", 64'(d), 64'h1);
    bus_wr(A_BD, 32'd7, 1'b0);
    @(negedge inclk);
    bus_rd(A_BD, d, h);
    chk("cs0_no_wr", 64'(d), 64'h1);
    cs = 1'b1; rd = 1'b0; addr = A_BD; #1;
    chk("no_rd_zero", 64'(rdata), 64'h0);
    cs = 1'b0;

    // Reset during DATA of a 0x00 frame
    bus_wr(A_BD, 32'd4);
    bus_wr(A_TX, 32'h00);
    repeat (8) @(negedge inclk);
    chk("mid_data_low", 64'(txd), 64'h0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_txd", 64'(txd), 64'h1);
    @(negedge inclk);
    rstn = 1'b1;
    bus_rd(A_ST, d, h);
    chk("mid_rst_status", 64'(d), 64'h4);
    capture(50, w, bz);
    chk("mid_rst_quiet", w, {14'h0, {50{1'b1}}});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Hard stop in case something wedges
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that acts as a responder on the CPU data-memory bus (chip select, read and write strobes, 32-bit address and data), alongside `DataMem`. The CPU stores bytes to a TX data register. The block buffers them in a small FIFO and serializes them as 8N1 frames on `txd`. Status and baud divisor registers are readable by the CPU; `hit` tells the top level to select this block's `rdata` over `DataMem`'s.

## Interface
- `BASE_ADDR`, default 32'h0000_FF00: 16-byte aligned base of the register window.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of two, at least 2.
- `DIV_RESET`, default 16'd434: reset value of BAUDDIV, in clock cycles per bit.
- `inclk` in 1: the single clock, the same clock that drives `DataMem`; all state updates on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `cs` in 1: bus chip select.
- `rd` in 1: read strobe.
- `wr` in 1: write strobe.
- `addr` in 32: byte address.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational.
- `hit` out 1: `cs` is high and `addr[31:4] == BASE_ADDR[31:4]`, combinational.
- `txd` out 1: serial output, idles high.

## Operation
- Decode: `addr[3:2]` selects a register and `addr[1:0]` is ignored. Offset 0x0 is TXDATA, 0x4 is STATUS, 0x8 is BAUDDIV; offset 0xC reads 0 and ignores writes.
- A write occurs at a rising edge when `hit && wr`. A read is combinational: `rdata` is valid when `hit && rd` and is 0 otherwise.
- TXDATA write: pushes `wdata[7:0]`. TXDATA reads 0.
- STATUS read:
  - bit0 busy: the FSM is not in IDLE or the FIFO is not empty.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow, sticky.
  - bits[7:4] FIFO count.
  - All other bits 0.
- STATUS write: a write with `wdata[3]` = 1 clears overflow. No other STATUS bits are writable.
- BAUDDIV: read/write, 16 bits, zero-extended on read. A written value of 0 is stored as 1. A new divisor takes effect at the next bit-counter reload; a bit already in progress keeps its old length.
- FIFO push when full is dropped and sets overflow. If a push coincides with a pop while full, the push is accepted and the count is unchanged.
- FSM:
  - IDLE: `txd` is 1. If the FIFO is not empty, pop the head into the shift register, load the bit counter, and go to START.
  - START: `txd` is 0 for one bit period, then go to DATA.
  - DATA: send 8 bits, LSB first, one bit period each, then go to STOP.
  - STOP: `txd` is 1 for one bit period. At the end, if the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Bit period = BAUDDIV cycles. A frame is 10 bit periods.
- Width rules:
  - The bit counter is 16 bits and counts down to 1.
  - The data-bit index is 3 bits.
  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth.
  - The count is one bit wider than the pointers.

## Timing
- Reset (asynchronous, while `rstn` is 0):
  - `txd` = 1, FSM in IDLE, FIFO empty, overflow = 0, BAUDDIV = DIV_RESET.
  - `rdata` and `hit` follow their combinational equations. A STATUS read during reset returns 0x4.
- Reset mid-frame aborts the frame immediately: `txd` returns to 1 asynchronously and FIFO contents are lost.
- Latency: a TXDATA write at edge N makes the FIFO non-empty after edge N. The FSM pops at edge N+1, and `txd` falls after edge N+1.
- Each state holds for exactly BAUDDIV cycles. There are no extra cycles between START, DATA and STOP.
- If the FIFO is drained at the end of STOP, the next frame starts exactly 10×BAUDDIV cycles after the previous START.
- Reads have zero latency and never stall; the bus needs no wait states.

## Structure
- Shared header `io/uart_defs.vh` holds the register offsets, the STATUS bit positions and the FSM state encodings (IDLE, START, DATA, STOP).
- Sub-module `sync_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Behaviour: first-word fall-through, same clock and reset.
- Top-level integration: `rdata` is muxed as `hit ? uart_rdata : dmem_rdata`, and `DataMem`'s chip select is gated with `!hit`.

## Test plan
- Reset: with `rstn` low, `txd` = 1. A STATUS read returns 0x4 and a BAUDDIV read returns 434.
- Single frame: write BAUDDIV = 4, then TXDATA = 0x55.
  - `txd` falls one cycle after the write edge.
  - The 40-cycle waveform is 0 (start), then bits 1,0,1,0,1,0,1,0 (LSB first), then 1 (stop), with each level lasting 4 cycles.
- Back-to-back: with BAUDDIV = 2, write 0xA0 and 0x0F in consecutive cycles.
  - The second START begins exactly 20 cycles after the first, with no idle gap.
  - busy is 1 throughout both frames and 0 afterwards.
- Overflow: with BAUDDIV = 1000, write 6 bytes.
  - One byte is popped immediately, 4 fill the FIFO and the 6th is dropped.
  - STATUS reads count = 4, full = 1, overflow = 1.
  - Writing STATUS with `wdata` = 0x8 clears overflow.
- Decode: a read at BASE_ADDR + 0x10 gives `hit` = 0 and `rdata` = 0.
  - A write of 0 to BAUDDIV reads back as 1.
  - A write with `cs` = 0 has no effect.
- Reset mid-frame: assert `rstn` low during DATA.
  - `txd` goes to 1 immediately.
  - After release, STATUS reads 0x4 and no frame is emitted.
